// File: rtl/fp_to_posit_pipe.sv
// Three-stage streaming float -> posit<N,ES> converter with valid/ready handshake.
// Stages: decode/normalise, regime build and shift, round/negate/flag.
module fp_to_posit_pipe #(
   parameter int N  = 16,
   parameter int E  = 5,
   parameter int ES = 2,
   parameter int BS = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         in_rnd,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_inexact,
   output logic         out_nar,
   output logic         out_zero
);

   localparam int M  = N - E - 1;
   localparam int SW = E + BS + 1;
   localparam int BW = 2 + ES + M;
   localparam int L  = BW + N - 1;
   localparam logic signed [SW-1:0] BIAS = SW'((1 << (E - 1)) - 1);

   logic pipe_en;

   assign pipe_en  = out_ready || !out_valid;
   assign in_ready = pipe_en;

   logic         in_sign;
   logic [E-1:0] in_exp;
   logic [M-1:0] in_mant;

   assign in_sign = in_data[N-1];
   assign in_exp  = in_data[N-2 -: E];
   assign in_mant = in_data[M-1:0];

   logic [BS-1:0] lz;

   // Leading-zero count of the mantissa; the last hit in the loop is the highest set bit.
   always_comb begin
      lz = '0;
      for (int i = 0; i < M; i++) begin
         if (in_mant[i]) begin
            lz = BS'(M - 1 - i);
         end
      end
   end

   logic signed [SW-1:0] d_scale;
   logic [M-1:0]         d_frac;
   logic                 d_nar;
   logic                 d_zero;

   assign d_nar  = &in_exp;
   assign d_zero = (in_exp == '0) && (in_mant == '0);

   // Subnormals drop their leading one into the hidden position, lowering the scale to match.
   always_comb begin
      if (in_exp == '0) begin
         d_scale = -BIAS - $signed(SW'(lz));
         d_frac  = in_mant << (lz + BS'(1));
      end else begin
         d_scale = $signed(SW'(in_exp)) - BIAS;
         d_frac  = in_mant;
      end
   end

   logic                 s1_valid;
   logic                 s1_sign;
   logic                 s1_nar;
   logic                 s1_zero;
   logic                 s1_rnd;
   logic signed [SW-1:0] s1_scale;
   logic [M-1:0]         s1_frac;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_nar   <= 1'b0;
         s1_zero  <= 1'b0;
         s1_rnd   <= 1'b0;
         s1_scale <= '0;
         s1_frac  <= '0;
      end else if (pipe_en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign  <= in_sign;
            s1_nar   <= d_nar;
            s1_zero  <= d_zero;
            s1_rnd   <= in_rnd;
            s1_scale <= d_scale;
            s1_frac  <= d_frac;
         end
      end
   end

   logic signed [SW-1:0] k;
   logic [SW-1:0]        e_val;
   logic [SW-1:0]        sh_raw;
   logic [SW-1:0]        sh;
   logic                 run;
   logic [BW-1:0]        body;
   logic [L-1:0]         vec;
   logic [L-1:0]         fill;
   logic [L-1:0]         shifted;

   // The body starts with one run bit plus terminator; shifting right by (run length - 1)
   // while filling with the run bit produces the full regime ahead of exponent and fraction.
   always_comb begin
      k       = s1_scale >>> ES;
      e_val   = s1_scale & SW'((1 << ES) - 1);
      run     = ~k[SW-1];
      sh_raw  = run ? k : ~k;
      sh      = (sh_raw > SW'(N - 1)) ? SW'(N - 1) : sh_raw;
      body    = (BW'(run ? 2'b10 : 2'b01) << (ES + M)) | (BW'(e_val) << M) | BW'(s1_frac);
      vec     = {body, {(N - 1){1'b0}}};
      fill    = run ? ~({L{1'b1}} >> sh) : '0;
      shifted = (vec >> sh) | fill;
   end

   logic         s2_valid;
   logic         s2_sign;
   logic         s2_nar;
   logic         s2_zero;
   logic         s2_rnd;
   logic [N-2:0] s2_mag;
   logic         s2_guard;
   logic         s2_sticky;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_sign   <= 1'b0;
         s2_nar    <= 1'b0;
         s2_zero   <= 1'b0;
         s2_rnd    <= 1'b0;
         s2_mag    <= '0;
         s2_guard  <= 1'b0;
         s2_sticky <= 1'b0;
      end else if (pipe_en) begin
         s2_valid  <= s1_valid;
         s2_sign   <= s1_sign;
         s2_nar    <= s1_nar;
         s2_zero   <= s1_zero;
         s2_rnd    <= s1_rnd;
         s2_mag    <= shifted[L-1 -: N-1];
         s2_guard  <= shifted[L-N];
         s2_sticky <= |shifted[L-N-1:0];
      end
   end

   logic         inc;
   logic [N-1:0] sum;
   logic [N-2:0] mag_r;
   logic [N-1:0] res;
   logic [N-1:0] res_final;
   logic         res_inexact;

   // Rounding saturates at maxpos and never collapses a nonzero value to zero.
   always_comb begin
      inc = ~s2_rnd & s2_guard & (s2_sticky | s2_mag[0]);
      sum = {1'b0, s2_mag} + N'(inc);
      if (sum[N-1]) begin
         mag_r = '1;
      end else if (sum[N-2:0] == '0) begin
         mag_r = (N-1)'(1);
      end else begin
         mag_r = sum[N-2:0];
      end
      res = s2_sign ? ({N{1'b0}} - {1'b0, mag_r}) : {1'b0, mag_r};
      if (s2_nar) begin
         res_final = {1'b1, {(N - 1){1'b0}}};
      end else if (s2_zero) begin
         res_final = '0;
      end else begin
         res_final = res;
      end
      res_inexact = ~s2_nar & ~s2_zero & (s2_guard | s2_sticky);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_inexact <= 1'b0;
         out_nar     <= 1'b0;
         out_zero    <= 1'b0;
      end else if (pipe_en) begin
         out_valid   <= s2_valid;
         out_data    <= s2_valid ? res_final : '0;
         out_inexact <= s2_valid & res_inexact;
         out_nar     <= s2_valid & s2_nar;
         out_zero    <= s2_valid & s2_zero & ~s2_nar;
      end
   end

endmodule

// File: tb/tb_fp_to_posit_pipe.sv
// Bench for fp_to_posit_pipe: directed table, backpressure and reset sequences, then random
// traffic scored against a real-valued posit reference model.
module tb_fp_to_posit_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        in_rnd = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        out_inexact;
   logic        out_nar;
   logic        out_zero;

   fp_to_posit_pipe #(.N(16), .E(5), .ES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rnd(in_rnd),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_inexact(out_inexact), .out_nar(out_nar), .out_zero(out_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        inx;
      logic        nar;
      logic        zero;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [15:0] din;
      logic        rnd;
      logic [15:0] dout;
      logic        inx;
      logic        nar;
      logic        zero;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[11];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   lat_check = 1'b0;
   bit   stalled = 1'b0;
   logic [19:0] stall_word;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic real pow2(input int n);
      real r = 1.0;
      if (n >= 0) repeat (n) r = r * 2.0;
      else repeat (-n) r = r / 2.0;
      return r;
   endfunction

   // Value of a positive posit<16,2> pattern, decoded field by field.
   function automatic real posit_val(input int p);
      logic [15:0] b = p[15:0];
      int  i = 14;
      int  run = 0;
      int  kk;
      int  ee = 0;
      real f = 1.0;
      real w = 0.5;
      logic r0 = b[14];
      while (i >= 0 && b[i] == r0) begin
         run++;
         i--;
      end
      kk = r0 ? run - 1 : -run;
      i--;
      for (int j = 0; j < 2; j++) begin
         ee = ee * 2 + ((i >= 0) ? int'(b[i]) : 0);
         i--;
      end
      while (i >= 0) begin
         if (b[i]) f = f + w;
         w = w / 2.0;
         i--;
      end
      return f * pow2(4 * kk + ee);
   endfunction

   // Reference: exact float value, then nearest posits by binary search over the
   // monotonic positive pattern space, then the requested rounding.
   function automatic exp_t model(input logic [15:0] f, input logic rnd);
      exp_t r;
      logic [4:0] ex = f[14:10];
      logic [9:0] mt = f[9:0];
      real ax, mid;
      int lo, hi, m, res;
      bit exact;
      r.data = '0; r.inx = 0; r.nar = 0; r.zero = 0; r.cyc = 0;
      if (ex == 5'h1F) begin
         r.data = 16'h8000;
         r.nar = 1;
      end else if (ex == 0 && mt == 0) begin
         r.zero = 1;
      end else begin
         if (ex == 0) ax = real'(mt) * pow2(-24);
         else ax = (1024.0 + real'(mt)) * pow2(int'(ex) - 25);
         lo = 0;
         hi = 32767;
         while (lo < hi) begin
            m = (lo + hi + 1) / 2;
            if (posit_val(m) <= ax) lo = m;
            else hi = m - 1;
         end
         exact = (lo > 0) && (posit_val(lo) == ax);
         if (exact) res = lo;
         else if (lo == 0) res = 1;
         else if (rnd || lo == 32767) res = lo;
         else begin
            mid = (posit_val(lo) + posit_val(lo + 1)) / 2.0;
            if (ax > mid) res = lo + 1;
            else if (ax < mid) res = lo;
            else res = (lo % 2 == 0) ? lo : lo + 1;
         end
         r.inx = !exact;
         r.data = f[15] ? 16'(-res) : 16'(res);
      end
      return r;
   endfunction

   function automatic exp_t tbl_exp(input int i);
      exp_t r;
      r.data = tbl[i].dout; r.inx = tbl[i].inx; r.nar = tbl[i].nar; r.zero = tbl[i].zero; r.cyc = 0;
      return r;
   endfunction

   // Scoreboard and stall-stability monitor, sampled on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled)
            check_output("stall_hold", {12'b0, out_valid, out_data, out_inexact, out_nar, out_zero},
                         {12'b0, stall_word});
         stalled = 1'b0;
         if (out_valid && !out_ready) begin
            stalled = 1'b1;
            stall_word = {out_valid, out_data, out_inexact, out_nar, out_zero};
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check_output("unexpected_out", {16'b0, out_data}, 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check_output("result", {13'b0, out_data, out_inexact, out_nar, out_zero},
                            {13'b0, e.data, e.inx, e.nar, e.zero});
               if (lat_check) check_output("latency", cyc - e.cyc, 3);
            end
         end
      end
   end

   task automatic apply_stimulus(input logic [15:0] d, input logic r, input exp_t e);
      int n = 0;
      exp_t x = e;
      in_valid = 1'b1;
      in_data = d;
      in_rnd = r;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 50);
      if (in_ready) begin
         x.cyc = cyc;
         sb.push_back(x);
      end else begin
         check_output("in_ready_timeout", 0, 1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      while (sb.size() > 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      check_output("drain", sb.size(), 0);
   endtask

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int v;
      int guard_cnt;
      tbl[0]  = '{16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{16'hBC00, 1'b0, 16'hC000, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{16'h4000, 1'b0, 16'h4800, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{16'h3800, 1'b0, 16'h3800, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{16'h7BFF, 1'b1, 16'h7BFF, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{16'h7C00, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{16'h7E01, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};

      #1 rst_n = 1'b0;
      #1;
      check_output("reset_state", {11'b0, out_valid, out_data, out_inexact, out_nar, out_zero}, 0);
      check_output("reset_in_ready", in_ready, 1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] directed stream and corner vectors");
      lat_check = 1'b1;
      for (int i = 0; i < 11; i++) apply_stimulus(tbl[i].din, tbl[i].rnd, tbl_exp(i));
      drain();

      $display("[TB] backpressure");
      lat_check = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) apply_stimulus(tbl[i].din, tbl[i].rnd, tbl_exp(i));
            in_valid = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            check_output("bp_in_ready", in_ready, 0);
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      $display("[TB] reset mid-stream");
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) apply_stimulus(tbl[i].din, tbl[i].rnd, tbl_exp(i));
      in_valid = 1'b0;
      #1;
      check_output("pre_reset_valid", out_valid, 1);
      rst_n = 1'b0;
      sb.delete();
      #1;
      check_output("async_reset", {11'b0, out_valid, out_data, out_inexact, out_nar, out_zero}, 0);
      check_output("async_reset_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_output("post_reset_quiet", out_valid, 0);
      end
      @(posedge clk);
      #1;

      $display("[TB] random traffic");
      v = 0;
      guard_cnt = 0;
      while (v < 10000 && guard_cnt < 40000) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data = 16'($urandom);
         in_rnd = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (in_valid && in_ready) begin
            exp_t e;
            e = model(in_data, in_rnd);
            e.cyc = cyc;
            sb.push_back(e);
            v++;
         end
         @(posedge clk);
         #1;
         guard_cnt++;
      end
      check_output("random_count", v, 10000);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
